tx_mem_read_sched: RTL and testbench



---
 rtl/tx_mem_read_sched_if.sv | 45 ++++
 rtl/tx_mem_read_sched.sv | 171 +++++++++++++++++
 tb/tb_tx_mem_read_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_mem_read_sched_if.sv
// ----------------------------------------------------------------------------
// tx_mem_read_sched_if
//
// Bundles the request/grant/return signals and the memory read port of the
// Y line memory read scheduler. The scheduler uses the slave modport. The
// requesters and the memory together form the master side.
//
// Signals:
//   disp_req / disp_addr      display read request and word address
//   disp_gnt / disp_rvalid    display accept (combinational) / data valid
//   lane_req / lane_addr      four SPI lane requests, lane i at [i*AW +: AW]
//   lane_gnt / lane_rvalid    one-hot lane accept / one-hot lane data valid
//   rdata                     returned data, shared by every owner
//   mem_en / mem_addr         memory read enable and address
//   mem_rdata                 memory read data
// ----------------------------------------------------------------------------
interface tx_mem_read_sched_if #(
    parameter int AW = 16,
    parameter int DW = 12
);
    logic              disp_req;
    logic [AW-1:0]     disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [3:0]        lane_req;
    logic [4*AW-1:0]   lane_addr;
    logic [3:0]        lane_gnt;
    logic [3:0]        lane_rvalid;
    logic [DW-1:0]     rdata;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  disp_req, disp_addr, lane_req, lane_addr, mem_rdata,
        output disp_gnt, disp_rvalid, lane_gnt, lane_rvalid, rdata,
               mem_en, mem_addr
    );

    modport master (
        output disp_req, disp_addr, lane_req, lane_addr, mem_rdata,
        input  disp_gnt, disp_rvalid, lane_gnt, lane_rvalid, rdata,
               mem_en, mem_addr
    );
endinterface

// File: rtl/tx_mem_read_sched.sv
// ----------------------------------------------------------------------------
// tx_mem_read_sched
//
// Shares the single read port of the Tx Y line memory between the HDMI
// display fetch and the four SPI transmit lanes. At most one read is issued
// per cycle. Each read carries an owner tag down a pipeline so that the
// returned word is routed back to its owner RD_LAT+2 cycles after the grant.
//
// Ports:
//   Cclk   clock
//   rstn   synchronous active-low reset
//   bus    tx_mem_read_sched_if.slave (requests, grants, returns, memory port)
//
// Parameters:
//   AW        memory word-address width
//   DW        memory data width
//   RD_LAT    memory read latency, mem_en to mem_rdata valid (1..4)
//   MAX_WAIT  lane wait limit for the starvation guard (2..255)
//
// Optional feature macro: STARVE_GUARD_EN
//   When defined, each lane has a wait counter. A lane that has waited
//   MAX_WAIT cycles is served ahead of the display. When undefined, the
//   display has absolute priority.
// ----------------------------------------------------------------------------
module tx_mem_read_sched #(
    parameter int AW       = 16,
    parameter int DW       = 12,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic                Cclk,
    input  logic                rstn,
    tx_mem_read_sched_if.slave  bus
);
    // Owner codes 0..3 are the lanes and 4 is the display.
    localparam logic [2:0] OWN_DISP = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [2:0] owner;
    } tag_t;

    logic [1:0]    rr_ptr_q, rr_ptr_d;
    tag_t          tag_q [RD_LAT+1];
    logic          mem_en_q;
    logic [AW-1:0] mem_addr_q;
    logic          disp_rv_q;
    logic [3:0]    lane_rv_q;
    logic [DW-1:0] rdata_q;

    logic          disp_gnt_c;
    logic [3:0]    lane_gnt_c;
    logic [3:0]    starved;
    logic          grant_any;
    logic [AW-1:0] win_addr;
    logic [2:0]    win_owner;

    // Picks the first set bit of mask at or after ptr, wrapping 3 -> 0.
    // The loop runs from the farthest position to the nearest one, so the
    // nearest set bit is the last assignment and takes effect.
    function automatic logic [3:0] rrPick(input logic [3:0] mask,
                                          input logic [1:0] ptr);
        logic [3:0] pick;
        logic [1:0] idx;
        pick = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (mask[idx]) pick = 4'b0001 << idx;
        end
        return pick;
    endfunction

`ifdef STARVE_GUARD_EN
    logic [7:0] wait_q [4];

    // A lane is starved only while it is still requesting.
    always_comb begin
        for (int i = 0; i < 4; i++)
            starved[i] = bus.lane_req[i] && (wait_q[i] == 8'(MAX_WAIT));
    end

    // Wait counters count cycles of unserved request and saturate at the
    // limit. They clear on a grant or when the lane stops requesting.
    always_ff @(posedge Cclk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rstn || !bus.lane_req[i] || lane_gnt_c[i])
                wait_q[i] <= '0;
            else if (wait_q[i] != 8'(MAX_WAIT))
                wait_q[i] <= wait_q[i] + 8'd1;
        end
    end
`else
    assign starved = 4'b0000;
`endif

    // Arbitration: starved lanes first, then the display, then the lanes in
    // round-robin order. No grant is given while reset is asserted.
    always_comb begin
        disp_gnt_c = 1'b0;
        lane_gnt_c = 4'b0000;
        if (rstn) begin
            if (|starved)
                lane_gnt_c = rrPick(starved, rr_ptr_q);
            else if (bus.disp_req)
                disp_gnt_c = 1'b1;
            else
                lane_gnt_c = rrPick(bus.lane_req, rr_ptr_q);
        end
    end

    // Winner address, owner tag and next round-robin pointer. The pointer
    // moves past a granted lane and is left alone by a display grant.
    always_comb begin
        grant_any = disp_gnt_c | (|lane_gnt_c);
        win_addr  = bus.disp_addr;
        win_owner = OWN_DISP;
        rr_ptr_d  = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (lane_gnt_c[i]) begin
                win_addr  = bus.lane_addr[i*AW +: AW];
                win_owner = 3'(i);
                rr_ptr_d  = 2'(i + 1);
            end
        end
    end

    // Issue, tag pipeline and return path. Tag stage RD_LAT lines up with
    // the cycle in which mem_rdata is valid. The data and owner strobe are
    // registered from that stage, so they appear RD_LAT+2 cycles after the
    // grant. rdata keeps its last value between returns.
    always_ff @(posedge Cclk) begin
        if (!rstn) begin
            rr_ptr_q   <= 2'd0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            disp_rv_q  <= 1'b0;
            lane_rv_q  <= 4'b0000;
            rdata_q    <= '0;
            for (int k = 0; k <= RD_LAT; k++)
                tag_q[k] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            mem_en_q <= grant_any;
            if (grant_any)
                mem_addr_q <= win_addr;

            tag_q[0] <= '{valid: grant_any, owner: win_owner};
            for (int k = 1; k <= RD_LAT; k++)
                tag_q[k] <= tag_q[k-1];

            disp_rv_q <= 1'b0;
            lane_rv_q <= 4'b0000;
            if (tag_q[RD_LAT].valid) begin
                rdata_q <= bus.mem_rdata;
                if (tag_q[RD_LAT].owner == OWN_DISP)
                    disp_rv_q <= 1'b1;
                else
                    lane_rv_q <= 4'b0001 << tag_q[RD_LAT].owner[1:0];
            end
        end
    end

    assign bus.disp_gnt    = disp_gnt_c;
    assign bus.lane_gnt    = lane_gnt_c;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.disp_rvalid = disp_rv_q;
    assign bus.lane_rvalid = lane_rv_q;
    assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_tx_mem_read_sched.sv
// ----------------------------------------------------------------------------
// tb_tx_mem_read_sched
//
// Directed bench for tx_mem_read_sched at default parameters. A vector table
// drives one cycle per row and holds hand-computed grants, memory issue and
// returns. Hand-written sequences cover display-versus-lane ordering,
// starvation, reset mid-flight and a display burst. A registered memory
// model returns memModel(addr) one cycle after mem_en.
// ----------------------------------------------------------------------------
module tb_tx_mem_read_sched;
    localparam int AW = 16;
    localparam int DW = 12;

    logic Cclk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 Cclk = ~Cclk;

    tx_mem_read_sched_if #(.AW(AW), .DW(DW)) bus ();

    tx_mem_read_sched #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(8)) dut (
        .Cclk (Cclk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic logic [DW-1:0] memModel(input logic [AW-1:0] a);
        return DW'(a * 16'd7 + 16'h03C1);
    endfunction

    // Memory with one cycle of read latency.
    always @(posedge Cclk) begin
        if (bus.mem_en)
            bus.mem_rdata <= memModel(bus.mem_addr);
    end

    task automatic applyStimulus(input logic dReq, input logic [AW-1:0] dAddr,
                                 input logic [3:0] lReq);
        bus.disp_req  = dReq;
        bus.disp_addr = dAddr;
        bus.lane_req  = lReq;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic endCycle();
        @(posedge Cclk);
        #1;
    endtask

    typedef struct {
        logic          dReq;
        logic [15:0]   dAddr;
        logic [3:0]    lReq;
        logic          expDGnt;
        logic [3:0]    expLGnt;
        logic          expMemEn;
        logic [15:0]   expMemAddr;
        logic          expDRv;
        logic [3:0]    expLRv;
        logic          chkRd;
        logic [15:0]   rdAddr;
    } vec_t;

    vec_t vecs [15];

    initial begin
        // Lane addresses: lane0 0x0020, lane1 0x0A01, lane2 0x0123, lane3 0x0B03
        bus.lane_addr = {16'h0B03, 16'h0123, 16'h0A01, 16'h0020};

        vecs[0]  = '{0, 16'h0000, 4'b0100, 0, 4'b0100, 0, 16'h0000, 0, 4'b0000, 0, 16'h0000};
        vecs[1]  = '{0, 16'h0000, 4'b0000, 0, 4'b0000, 1, 16'h0123, 0, 4'b0000, 0, 16'h0000};
        vecs[2]  = '{0, 16'h0000, 4'b1111, 0, 4'b1000, 0, 16'h0123, 0, 4'b0000, 0, 16'h0000};
        vecs[3]  = '{0, 16'h0000, 4'b1111, 0, 4'b0001, 1, 16'h0B03, 0, 4'b0100, 1, 16'h0123};
        vecs[4]  = '{0, 16'h0000, 4'b1111, 0, 4'b0010, 1, 16'h0020, 0, 4'b0000, 0, 16'h0000};
        vecs[5]  = '{0, 16'h0000, 4'b1111, 0, 4'b0100, 1, 16'h0A01, 0, 4'b1000, 1, 16'h0B03};
        vecs[6]  = '{1, 16'h0010, 4'b0001, 1, 4'b0000, 1, 16'h0123, 0, 4'b0001, 1, 16'h0020};
        vecs[7]  = '{0, 16'h0000, 4'b0001, 0, 4'b0001, 1, 16'h0010, 0, 4'b0010, 1, 16'h0A01};
        vecs[8]  = '{1, 16'h0005, 4'b1010, 1, 4'b0000, 1, 16'h0020, 0, 4'b0100, 1, 16'h0123};
        vecs[9]  = '{0, 16'h0000, 4'b1010, 0, 4'b0010, 1, 16'h0005, 1, 4'b0000, 1, 16'h0010};
        vecs[10] = '{0, 16'h0000, 4'b1010, 0, 4'b1000, 1, 16'h0A01, 0, 4'b0001, 1, 16'h0020};
        vecs[11] = '{0, 16'h0000, 4'b0000, 0, 4'b0000, 1, 16'h0B03, 1, 4'b0000, 1, 16'h0005};
        vecs[12] = '{0, 16'h0000, 4'b0000, 0, 4'b0000, 0, 16'h0B03, 0, 4'b0010, 1, 16'h0A01};
        vecs[13] = '{0, 16'h0000, 4'b0000, 0, 4'b0000, 0, 16'h0B03, 0, 4'b1000, 1, 16'h0B03};
        vecs[14] = '{0, 16'h0000, 4'b0000, 0, 4'b0000, 0, 16'h0B03, 0, 4'b0000, 1, 16'h0B03};

        // Reset with every request asserted: no grants, all outputs zero.
        rstn = 1'b0;
        applyStimulus(1'b1, 16'h0044, 4'b1111);
        repeat (2) @(posedge Cclk);
        @(negedge Cclk);
        checkOutput("rst_dgnt",  bus.disp_gnt, 0);
        checkOutput("rst_lgnt",  bus.lane_gnt, 0);
        checkOutput("rst_memen", bus.mem_en, 0);
        checkOutput("rst_maddr", bus.mem_addr, 0);
        checkOutput("rst_drv",   bus.disp_rvalid, 0);
        checkOutput("rst_lrv",   bus.lane_rvalid, 0);
        checkOutput("rst_rdata", bus.rdata, 0);
        endCycle();
        rstn = 1'b1;

        // Vector table: one row per cycle.
        for (int r = 0; r < 15; r++) begin
            applyStimulus(vecs[r].dReq, vecs[r].dAddr, vecs[r].lReq);
            @(negedge Cclk);
            checkOutput($sformatf("v%0d_dgnt", r),  bus.disp_gnt,    vecs[r].expDGnt);
            checkOutput($sformatf("v%0d_lgnt", r),  bus.lane_gnt,    vecs[r].expLGnt);
            checkOutput($sformatf("v%0d_memen", r), bus.mem_en,      vecs[r].expMemEn);
            checkOutput($sformatf("v%0d_maddr", r), bus.mem_addr,    vecs[r].expMemAddr);
            checkOutput($sformatf("v%0d_drv", r),   bus.disp_rvalid, vecs[r].expDRv);
            checkOutput($sformatf("v%0d_lrv", r),   bus.lane_rvalid, vecs[r].expLRv);
            if (vecs[r].chkRd)
                checkOutput($sformatf("v%0d_rdata", r), bus.rdata, memModel(vecs[r].rdAddr));
            endCycle();
        end

        // Display and lane 0 together: display first, lane 0 next cycle,
        // returns exactly one cycle apart.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(c == 0, 16'h0010, (c < 2) ? 4'b0001 : 4'b0000);
            @(negedge Cclk);
            checkOutput("t3_dgnt", bus.disp_gnt, c == 0);
            checkOutput("t3_lgnt", bus.lane_gnt, (c == 1) ? 4'b0001 : 4'b0000);
            checkOutput("t3_drv",  bus.disp_rvalid, c == 3);
            checkOutput("t3_lrv",  bus.lane_rvalid, (c == 4) ? 4'b0001 : 4'b0000);
            if (c == 3) checkOutput("t3_rdata_d", bus.rdata, memModel(16'h0010));
            if (c == 4) checkOutput("t3_rdata_l", bus.rdata, memModel(16'h0020));
            endCycle();
        end

        // Display held with lane 1 requesting: the guard lets lane 1 in on
        // its 9th request cycle, otherwise the display always wins.
        for (int c = 1; c <= 12; c++) begin
            applyStimulus(1'b1, 16'h0300, 4'b0010);
            @(negedge Cclk);
`ifdef STARVE_GUARD_EN
            checkOutput("t4_dgnt", bus.disp_gnt, c != 9);
            checkOutput("t4_lgnt", bus.lane_gnt, (c == 9) ? 4'b0010 : 4'b0000);
`else
            checkOutput("t4_dgnt", bus.disp_gnt, 1);
            checkOutput("t4_lgnt", bus.lane_gnt, 0);
`endif
            endCycle();
        end
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        repeat (4) endCycle();

        // Lane 3 grant followed by a one-cycle reset: the in-flight read
        // must never return.
        applyStimulus(1'b0, 16'h0000, 4'b1000);
        @(negedge Cclk);
        checkOutput("t5_lgnt3", bus.lane_gnt, 4'b1000);
        endCycle();
        rstn = 1'b0;
        applyStimulus(1'b1, 16'h0077, 4'b1111);
        @(negedge Cclk);
        checkOutput("t5_rst_dgnt", bus.disp_gnt, 0);
        checkOutput("t5_rst_lgnt", bus.lane_gnt, 0);
        endCycle();
        rstn = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            @(negedge Cclk);
            checkOutput("t5_memen", bus.mem_en, 0);
            checkOutput("t5_maddr", bus.mem_addr, 0);
            checkOutput("t5_drv",   bus.disp_rvalid, 0);
            checkOutput("t5_lrv",   bus.lane_rvalid, 0);
            checkOutput("t5_rdata", bus.rdata, 0);
            endCycle();
        end

        // Move rr_ptr to 2, reset, and confirm the search starts at lane 0.
        applyStimulus(1'b0, 16'h0000, 4'b0010);
        @(negedge Cclk);
        checkOutput("t5_lgnt1", bus.lane_gnt, 4'b0010);
        endCycle();
        rstn = 1'b0;
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        endCycle();
        rstn = 1'b1;
        applyStimulus(1'b0, 16'h0000, 4'b1111);
        @(negedge Cclk);
        checkOutput("t5_rrptr0", bus.lane_gnt, 4'b0001);
        endCycle();
        applyStimulus(1'b0, 16'h0000, 4'b0000);
        repeat (4) endCycle();

        // Display burst over addresses 0..7.
        for (int c = 0; c < 11; c++) begin
            applyStimulus(c < 8, AW'(c), 4'b0000);
            @(negedge Cclk);
            checkOutput("t6_dgnt", bus.disp_gnt, c < 8);
            checkOutput("t6_memen", bus.mem_en, (c >= 1) && (c <= 8));
            if (c >= 1 && c <= 8)
                checkOutput("t6_maddr", bus.mem_addr, 64'(c - 1));
            checkOutput("t6_drv", bus.disp_rvalid, c >= 3);
            if (c >= 3)
                checkOutput("t6_rdata", bus.rdata, memModel(AW'(c - 3)));
            endCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
